gray_arbiter: RTL
=================

# gray_arbiter

Round-robin controller that shares one 3-bit Gray-code step counter (000→001→011→010→110→111→101→100→000, sticky overflow on wrap, synchronous active-high reset and enable) between two requesters. A granted requester asks for a number of steps. The block clears the counter, enables it for exactly that many cycles, and returns the final Gray value and overflow flag. It sits between the two requesting units and the counter instance and is the only driver of the counter's reset and enable.

## Interface
- LEN_W, default 4: width of the step-count inputs; the maximum request is 2^LEN_W−1 steps.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  2  per-requester level request; bit i belongs to requester i.
- Len0  in  LEN_W  step count for requester 0; sampled at grant.
- Len1  in  LEN_W  step count for requester 1; sampled at grant.
- Gnt  out  2  one-hot grant; held for the whole operation.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle completion pulse.
- Result  out  3  final counter Gray value of the last completed operation.
- Result_Ovf  out  1  counter overflow flag of the last completed operation.
- Cnt_Reset  out  1  drives the counter's synchronous reset.
- Cnt_En  out  1  drives the counter's enable.
- Cnt_Value  in  3  counter output.
- Cnt_Overflow  in  1  counter overflow output.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, DONE.
  - Cnt_Reset = (state==CLEAR).
  - Cnt_En = (state==RUN).
  - Done = (state==DONE).
  - Busy = (state!=IDLE).
- IDLE:
  - If Req==00, stay in IDLE.
  - Otherwise pick a winner:
    - Only one bit set: that requester wins.
    - Both bits set: the requester other than Last wins.
  - On the transition: Gnt ← one-hot winner, Rem ← winner's Len, then go to CLEAR.
- CLEAR: the counter clears at the end of this cycle. Next state is RUN if Rem≠0, else SETTLE.
- RUN: Rem decrements each cycle. When Rem==1 at the edge, go to SETTLE. Cnt_En is therefore high for exactly Len cycles.
- SETTLE: Cnt_Value and Cnt_Overflow are final. At the edge, Result ← Cnt_Value, Result_Ovf ← Cnt_Overflow, then go to DONE.
- DONE: Gnt is still asserted. At the edge: Gnt ← 00, Last ← granted index, then go to IDLE.
- Last resets to 1, so requester 0 wins the first tie.
- Req deasserting mid-operation is ignored; the operation completes.
- Len changes after grant are ignored.
- Result and Result_Ovf hold until the next DONE.
- Expected result for L steps: Gray(L mod 8); Result_Ovf=1 iff L≥8. The counter keeps stepping after overflow.
- Rem is LEN_W bits wide; there is no underflow, because RUN is never entered with Rem=0.

## Timing
- Reset (asynchronous, anytime, including mid-operation):
  - State ← IDLE, Gnt=00, Busy=0, Done=0, Cnt_En=0, Cnt_Reset=0.
  - Result=000, Result_Ovf=0, Last=1, Rem=0.
- Grant timeline, with Req sampled at edge t while in IDLE:
  - CLEAR: cycle t+1.
  - RUN: cycles t+2 … t+1+L.
  - SETTLE: cycle t+2+L.
  - DONE: cycle t+3+L.
  - IDLE: cycle t+4+L.
- Gnt is high for L+3 cycles.
- L=0: CLEAR→SETTLE→DONE; Gnt is high for 3 cycles; Result=000, Ovf=0.
- There is at least one IDLE cycle between consecutive grants. A request held through Done is re-arbitrated in that IDLE cycle.
- All outputs are Moore (decoded from registered state or registered values).

## Test plan
- Reset released, Req=01, Len0=3 → Gnt=01 for 6 cycles, Cnt_En high for 3 cycles, Done pulse; Result=010, Result_Ovf=0.
- Req=11 held, Len0=7, Len1=8 → grants alternate 0,1,0; requester 0 gets Result=100/Ovf=0; requester 1 gets Result=000/Ovf=1; exactly one IDLE cycle between grants.
- Req=10, Len1=0 → Gnt=10 for 3 cycles, no Cnt_En pulse, one Cnt_Reset cycle; Result=000, Ovf=0.
- Req=01, Len0=10; drop Req and change Len0 to 2 during RUN → Cnt_En still high for 10 cycles; Result=011, Ovf=1.
- Assert Reset mid-RUN (Len0=15) → outputs go to reset values immediately; after release with Req=01, Len0=15 → Result=100, Ovf=1.

Source files
------------

// File: rtl/gray_arbiter.sv
// gray_arbiter: round-robin front end for a shared 3-bit Gray step counter.
// Two requesters compete for the counter. The winner's step count is latched
// at grant, the counter is cleared, then enabled for exactly that many cycles.
// The final Gray value and overflow flag are captured once the counter settles.
// Every output comes straight from a register, so all outputs are Moore.
module gray_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [LEN_W-1:0] Len0,
    input  logic [LEN_W-1:0] Len1,
    output logic [1:0]       Gnt,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       Result,
    output logic             Result_Ovf,
    output logic             Cnt_Reset,
    output logic             Cnt_En,
    input  logic [2:0]       Cnt_Value,
    input  logic             Cnt_Overflow
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             last;
    logic             winner;

    // Arbitration: a lone request wins outright; on a tie the requester
    // that was not served last wins.
    always_comb begin
        winner = Req[1];
        if (Req == 2'b11) begin
            winner = ~last;
        end
    end

    // Control FSM; every output is a flop updated on the transition that
    // enters the state it decodes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Gnt        <= 2'b00;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Cnt_Reset  <= 1'b0;
            Cnt_En     <= 1'b0;
            Result     <= 3'b000;
            Result_Ovf <= 1'b0;
            last       <= 1'b1;
            rem        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req != 2'b00) begin
                        Gnt       <= winner ? 2'b10 : 2'b01;
                        rem       <= winner ? Len1 : Len0;
                        Busy      <= 1'b1;
                        Cnt_Reset <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    // The counter clears at this edge; a zero-length request
                    // skips RUN so the enable never pulses.
                    Cnt_Reset <= 1'b0;
                    if (rem != '0) begin
                        Cnt_En <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= SETTLE;
                    end
                end
                RUN: begin
                    rem <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        Cnt_En <= 1'b0;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The last enabled step has landed; capture it.
                    Result     <= Cnt_Value;
                    Result_Ovf <= Cnt_Overflow;
                    Done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    last  <= Gnt[1];
                    Gnt   <= 2'b00;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Gnt       <= 2'b00;
                    Busy      <= 1'b0;
                    Done      <= 1'b0;
                    Cnt_Reset <= 1'b0;
                    Cnt_En    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
